// File: rtl/load_store_unit.sv
// Load/store controller between the execute stage and a word-only, registered-read data memory.
// Sub-word stores use read-modify-write; loads are lane-extracted and sign/zero-extended.
module load_store_unit #(
  parameter int WORD_ADDR_W = 10
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     REQ,
  input  logic                     WR,
  input  logic [1:0]               SIZE,
  input  logic                     SIGNED,
  input  logic [WORD_ADDR_W+1:0]   ADDR,
  input  logic [31:0]              WDATA,
  output logic                     READY,
  output logic                     ACK,
  output logic                     ERR,
  output logic [31:0]              RDATA,
  input  logic                     M_LOADING,
  output logic                     M_WE,
  output logic [WORD_ADDR_W-1:0]   M_ADDRESS,
  output logic [31:0]              M_DATA,
  input  logic [31:0]              M_Q
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]             state_reg, state_next;
  logic                   wr_reg, signed_reg, err_reg;
  logic [1:0]             size_reg;
  logic [WORD_ADDR_W+1:0] addr_reg;
  logic [31:0]            wdata_reg, merged_reg, rdata_reg;
  logic [31:0]            merged_next, load_value;
  logic [7:0]             byte_q;
  logic [15:0]            half_q;
  logic                   illegal_in, accept, word_store;
  logic [1:0]             lane;

  assign illegal_in = (SIZE == 2'b11) || (SIZE == 2'b01 && ADDR[0]) ||
                      (SIZE == 2'b10 && ADDR[1:0] != 2'b00);
  assign READY      = (state_reg == IDLE) && !M_LOADING;
  assign accept     = READY && REQ;
  assign word_store = wr_reg && (size_reg == 2'b10);
  assign lane       = addr_reg[1:0];

  assign ACK       = (state_reg == DONE);
  assign ERR       = (state_reg == DONE) && err_reg;
  assign RDATA     = rdata_reg;
  assign M_ADDRESS = addr_reg[WORD_ADDR_W+1:2];
  assign M_WE      = (state_reg == WRITE) || (state_reg == ISSUE && word_store);
  assign M_DATA    = (state_reg == WRITE) ? merged_reg : wdata_reg;

  assign byte_q = M_Q[8*lane +: 8];
  assign half_q = M_Q[16*lane[1] +: 16];

  always_comb begin
    case (size_reg)
      2'b00:   load_value = {{24{signed_reg & byte_q[7]}}, byte_q};
      2'b01:   load_value = {{16{signed_reg & half_q[15]}}, half_q};
      default: load_value = M_Q;
    endcase
  end

  // Each byte lane of the merged word takes store data if the access covers it, else the read value.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      logic hit;
      logic [7:0] src;
      assign hit = (size_reg == 2'b00) ? (lane == 2'(gi)) : (lane[1] == 1'(gi / 2));
      assign src = (size_reg == 2'b00) ? wdata_reg[7:0] : wdata_reg[8*(gi%2) +: 8];
      assign merged_next[8*gi +: 8] = hit ? src : M_Q[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = illegal_in ? DONE : ISSUE;
      ISSUE:   state_next = word_store ? DONE : WAIT;
      WAIT:    state_next = wr_reg ? WRITE : DONE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg  <= IDLE;
      wr_reg     <= 1'b0;
      size_reg   <= 2'b00;
      signed_reg <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= 32'd0;
      err_reg    <= 1'b0;
      merged_reg <= 32'd0;
      rdata_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        wr_reg     <= WR;
        size_reg   <= SIZE;
        signed_reg <= SIGNED;
        addr_reg   <= ADDR;
        wdata_reg  <= WDATA;
        err_reg    <= illegal_in;
      end
      if (state_reg == WAIT) begin
        if (wr_reg) merged_reg <= merged_next;
        else        rdata_reg  <= load_value;
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side controller for `data_memory`. It accepts byte, halfword and word load/store requests from the CPU execute stage and drives the word-only memory port (`WE`/`ADDRESS`/`DATA`, reading back `Q`). Sub-word stores are done as read-modify-write. Loads are byte-lane extracted and sign/zero-extended. It sits between the datapath and `data_memory`, and holds off while the memory image is being loaded.

## Interface
- `WORD_ADDR_W`, default 10: memory word-address width. Byte address width is `WORD_ADDR_W+2`.
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RST_N`  in  1  reset, synchronous, active-low.
- `REQ`  in  1  request valid; sampled only when `READY`=1.
- `WR`  in  1  1 = store, 0 = load.
- `SIZE`  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- `SIGNED`  in  1  load extension: 1 = sign-extend, 0 = zero-extend. Ignored for word accesses and stores.
- `ADDR`  in  WORD_ADDR_W+2  byte address; little-endian lanes (`ADDR[1:0]`=0 is bits 7:0).
- `WDATA`  in  32  store data, right-aligned (byte in 7:0, half in 15:0).
- `READY`  out  1  unit can accept a request this cycle.
- `ACK`  out  1  one-cycle completion pulse.
- `ERR`  out  1  valid with `ACK`: request was misaligned or illegal.
- `RDATA`  out  32  load result; valid with `ACK`, held until the next load completes.
- `M_LOADING`  in  1  memory file-load in progress (tied to `read_file`).
- `M_WE`  out  1  memory write enable.
- `M_ADDRESS`  out  WORD_ADDR_W  memory word address.
- `M_DATA`  out  32  memory write data.
- `M_Q`  in  32  memory read data, registered: valid the cycle after `M_ADDRESS` is presented.

## Operation
- **Request latching.** On an accepted request (`REQ && READY` at an edge), latch `WR`, `SIZE`, `SIGNED`, `ADDR` and `WDATA`.
- **Address and data outputs.** `M_ADDRESS` = latched `ADDR[WORD_ADDR_W+1:2]`. `M_DATA` and `M_WE` are decoded from state.
- **IDLE.**
  - `READY` = !`M_LOADING`.
  - Accepted and illegal (`SIZE`=11, half with `ADDR[0]`=1, or word with `ADDR[1:0]`≠0) → DONE with `ERR`.
  - Accepted and legal → ISSUE.
- **ISSUE.**
  - Word store: `M_WE`=1, `M_DATA`=`WDATA`; → DONE.
  - Otherwise: `M_WE`=0 (read); → WAIT.
- **WAIT.** `M_Q` is valid.
  - Load: register extracted lane into `RDATA`; → DONE.
    - Byte: `M_Q[8*ADDR[1:0]+:8]`.
    - Half: `M_Q[16*ADDR[1]+:16]`.
    - Extension per `SIGNED`.
  - Sub-word store: register merged word (`M_Q` with the addressed byte/half replaced by `WDATA` low bits); → WRITE.
- **WRITE.** `M_WE`=1, `M_DATA`=merged word; → DONE.
- **DONE.**
  - `ACK`=1 for one cycle; `ERR`=1 if illegal.
  - `RDATA` is unchanged on stores and errors.
  - → IDLE.
- **Ignored request inputs.** `REQ` is ignored in every state except IDLE. Requester inputs may change freely after acceptance.
- **Memory-load interlock.** `M_LOADING` high blocks acceptance only; an in-flight operation completes normally.
- **Errored requests.** An errored request never asserts `M_WE` and never reads memory.

## Timing
- **Reset.** `RST_N`=0 at an edge → state IDLE, `ACK`=0, `ERR`=0, `RDATA`=0, `M_DATA`=0, internal latches 0, so `M_ADDRESS`=0. In the following cycle `M_WE`=0 and `READY`=!`M_LOADING`.
- **Reset mid-operation.** The operation is aborted and no `ACK` is issued.
  - A write whose `M_WE`=1 cycle coincides with the reset edge still commits in memory (same edge).
  - A reset in WAIT prevents the RMW write.
- **Latency.** Accept edge = end of cycle 0; `ACK` appears in:
  - cycle 1: error;
  - cycle 2: word store;
  - cycle 3: load;
  - cycle 4: sub-word store.
- **Throughput.** `READY`=0 during ISSUE/WAIT/WRITE/DONE. Next accept is possible in the cycle after DONE, so at best one word store every 3 cycles.
- **Write pulse.** `M_WE` is asserted for exactly one cycle per legal store, with `M_ADDRESS` and `M_DATA` stable in that cycle.
- **`ACK` pulse.** `ACK` is never high for two consecutive cycles.

## Test plan
- **Word store/load.** Word store `ADDR`=0x010, `WDATA`=0xDEADBEEF, then word load 0x010.
  - One `M_WE` pulse with `M_ADDRESS`=4.
  - `ACK` in cycle 2 for the store.
  - `ACK` in cycle 3 for the load, `RDATA`=0xDEADBEEF, `ERR`=0.
- **Byte store RMW.** Memory word 1 = 0x11223344; byte store `ADDR`=0x005, `WDATA`=0x000000AB.
  - Read in ISSUE.
  - Write 0x1122AB44 in WRITE.
  - `ACK` in cycle 4.
- **Load extension.** Memory word 2 = 0x80FF7F80.
  - Signed byte @0x008 → 0xFFFFFF80.
  - Unsigned byte @0x008 → 0x00000080.
  - Signed half @0x00A → 0xFFFF80FF.
  - Unsigned half @0x00A → 0x000080FF.
- **Illegal requests.** Half store @0x003; word load @0x002; `SIZE`=11.
  - Each gives `ACK`=`ERR`=1 in cycle 1.
  - `M_WE` stays 0, `RDATA` unchanged.
- **Reset mid-RMW.** Reset asserted in the WAIT cycle of a byte store → no `M_WE` pulse, no `ACK`, memory unchanged, all outputs at reset values.
- **Memory-load interlock.** `M_LOADING`=1 with `REQ` held high for 5 cycles → `READY`=0, no accept. Request is accepted on the first edge after `M_LOADING` falls.
